// File: rtl/exe_pkg.sv
// Shared definitions for the multi-cycle execute stage.
//   - EXE_CMD opcode encodings
//   - shifter type encodings (Shift_operand[6:5])
//   - bit positions of {N,Z,C,V} inside the 4-bit status word
//   - multiplier FSM state enum and packed flag struct
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;  // also LDR/STR address
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;  // also CMP
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;  // also TST
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;
    localparam logic [3:0] CMD_MLA = 4'b1011;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Field order matches the {N,Z,C,V} status word.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic is_mul_cmd(input logic [3:0] cmd);
        return (cmd == CMD_MUL) || (cmd == CMD_MLA);
    endfunction

endpackage

// File: rtl/val2_gen_p.sv
// Second-operand generator (ARM shifter operand), purely combinational.
// Ports:
//   val_rm        in  WIDTH  register operand Rm
//   shift_operand in  12     ARM shifter operand field
//   imm           in  1      immediate form (rotated 8-bit constant)
//   mem_en        in  1      memory op: offset is the raw 12-bit field
//   val2          out WIDTH  resulting second operand
module val2_gen_p
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_rm,
    input  logic [11:0]      shift_operand,
    input  logic             imm,
    input  logic             mem_en,
    output logic [WIDTH-1:0] val2
);

    // Rotate right within WIDTH; n == 0 yields x because x << WIDTH is 0.
    function automatic logic [WIDTH-1:0] ror_w(input logic [WIDTH-1:0] x,
                                               input logic [4:0]       n);
        return (x >> n) | (x << (WIDTH - int'(n)));
    endfunction

    logic [WIDTH-1:0] imm8;
    logic [4:0]       rot_amt;
    logic [4:0]       sh_amt;
    logic [1:0]       sh_type;

    assign imm8    = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
    assign rot_amt = {shift_operand[11:8], 1'b0};
    assign sh_amt  = shift_operand[11:7];
    assign sh_type = shift_operand[6:5];

    always_comb begin
        val2 = val_rm;
        if (mem_en) begin
            val2 = {{(WIDTH-12){1'b0}}, shift_operand};
        end else if (imm) begin
            val2 = ror_w(imm8, rot_amt);
        end else begin
            case (sh_type)
                SH_LSL:  val2 = val_rm << sh_amt;
                SH_LSR:  val2 = val_rm >> sh_amt;
                SH_ASR:  val2 = $signed(val_rm) >>> sh_amt;
                default: val2 = ror_w(val_rm, sh_amt);
            endcase
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// Registered execute stage: single-cycle ALU plus an iterative shift-add
// multiplier for MUL/MLA. The output register doubles as EXE/MEM.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, flush     ID/EXE valid, kill instruction currently in EXE
//   EXE_CMD, S          opcode, update-status bit
//   MEM_R_EN, MEM_W_EN  memory op (Val2 = zero-extended Shift_operand)
//   PC, Signed_imm_24   branch target inputs
//   Val_Rn/Rm/Rs        register operands (MUL = Rm*Rs, MLA = Rm*Rs+Rn)
//   imm, Shift_operand  shifter operand form and field
//   SR                  current {N,Z,C,V}
//   stall               hold ID/EXE and earlier stages
//   out_valid, ALU_result, Br_addr, status, status_we   registered results
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1,
    parameter int BR_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [3:0]       EXE_CMD,
    input  logic             S,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] Val_Rn,
    input  logic [WIDTH-1:0] Val_Rm,
    input  logic [WIDTH-1:0] Val_Rs,
    input  logic             imm,
    input  logic [11:0]      Shift_operand,
    input  logic [23:0]      Signed_imm_24,
    input  logic [3:0]       SR,
    output logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] Br_addr,
    output logic [3:0]       status,
    output logic             status_we
);

    localparam int MUL_CYC = WIDTH / MUL_BITS;
    localparam int CNT_W   = $clog2(MUL_CYC + 1);

    mul_state_e       state, state_nxt;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] br_calc;
    logic             is_mul, take, alu_fire, mul_start;

    // Multiplier working registers
    logic [WIDTH-1:0] mcand, mplier, acc, pp;
    logic [CNT_W-1:0] cnt;
    logic             s_q;
    logic [1:0]       cv_q;
    logic [WIDTH-1:0] br_q;

    // ALU
    logic [WIDTH-1:0] alu_res, b_in;
    logic [WIDTH:0]   sum;
    logic             arith, cin;
    flags_t           alu_flags, mul_flags;

    // N and Z of the incoming status are always recomputed, never consumed.
    logic unused_sr;
    assign unused_sr = ^{SR[FLAG_N], SR[FLAG_Z]};

    val2_gen_p #(.WIDTH(WIDTH)) u_val2 (
        .val_rm        (Val_Rm),
        .shift_operand (Shift_operand),
        .imm           (imm),
        .mem_en        (MEM_R_EN | MEM_W_EN),
        .val2          (val2)
    );

    assign br_calc = PC + ({{(WIDTH-24){Signed_imm_24[23]}}, Signed_imm_24} << BR_SHIFT);

    assign is_mul    = is_mul_cmd(EXE_CMD);
    assign take      = in_valid & ~flush & (state == ST_IDLE);
    assign alu_fire  = take & ~is_mul;
    assign mul_start = take & is_mul;

    // ------------------------------------------------------------------
    // Single-cycle ALU. Subtraction is a + ~b + cin so the carry out is
    // directly the ARM NOT-borrow, and one overflow rule covers add/sub.
    // ------------------------------------------------------------------
    always_comb begin
        arith   = 1'b0;
        cin     = 1'b0;
        b_in    = val2;
        alu_res = '0;
        case (EXE_CMD)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_AND: alu_res = Val_Rn & val2;
            CMD_ORR: alu_res = Val_Rn | val2;
            CMD_EOR: alu_res = Val_Rn ^ val2;
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = SR[FLAG_C]; end
            CMD_SUB: begin arith = 1'b1; cin = 1'b1; b_in = ~val2; end
            CMD_SBC: begin arith = 1'b1; cin = SR[FLAG_C]; b_in = ~val2; end
            default: alu_res = '0;
        endcase

        sum = {1'b0, Val_Rn} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin};

        alu_flags.c = SR[FLAG_C];
        alu_flags.v = SR[FLAG_V];
        if (arith) begin
            alu_res     = sum[WIDTH-1:0];
            alu_flags.c = sum[WIDTH];
            alu_flags.v = (Val_Rn[WIDTH-1] == b_in[WIDTH-1]) &&
                          (sum[WIDTH-1] != Val_Rn[WIDTH-1]);
        end
        alu_flags.n = alu_res[WIDTH-1];
        alu_flags.z = (alu_res == '0);
    end

    // Partial product for the MUL_BITS multiplier bits retired this cycle.
    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier[i]) pp = pp + (mcand << i);
        end
    end

    always_comb begin
        mul_flags.n = acc[WIDTH-1];
        mul_flags.z = (acc == '0);
        mul_flags.c = cv_q[1];
        mul_flags.v = cv_q[0];
    end

    // ------------------------------------------------------------------
    // Multiplier FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = mul_start;
                if (mul_start) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (flush)                    state_nxt = ST_IDLE;
                else if (cnt == CNT_W'(1))    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (rst) stall = 1'b0;
    end

    // ------------------------------------------------------------------
    // Datapath / EXE-MEM register. In DONE the ID/EXE register still holds
    // the MUL (stall just dropped), so in_valid is ignored there and the
    // result is committed on the edge leaving DONE unless flushed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            status_we  <= 1'b0;
            ALU_result <= '0;
            Br_addr    <= '0;
            status     <= '0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            s_q        <= 1'b0;
            cv_q       <= 2'b00;
            br_q       <= '0;
        end else begin
            out_valid <= 1'b0;
            status_we <= 1'b0;

            if (alu_fire) begin
                ALU_result <= alu_res;
                Br_addr    <= br_calc;
                out_valid  <= 1'b1;
                status_we  <= S;
                if (S) status <= alu_flags;
            end

            if (mul_start) begin
                mcand  <= Val_Rm;
                mplier <= Val_Rs;
                acc    <= (EXE_CMD == CMD_MLA) ? Val_Rn : '0;
                cnt    <= CNT_W'(MUL_CYC);
                s_q    <= S;
                cv_q   <= {SR[FLAG_C], SR[FLAG_V]};
                br_q   <= br_calc;
            end

            if (state == ST_BUSY && !flush) begin
                acc    <= acc + pp;
                mcand  <= mcand << MUL_BITS;
                mplier <= mplier >> MUL_BITS;
                cnt    <= cnt - CNT_W'(1);
            end

            if (state == ST_DONE && !flush) begin
                ALU_result <= acc;
                Br_addr    <= br_q;
                out_valid  <= 1'b1;
                status_we  <= s_q;
                if (s_q) status <= mul_flags;
            end
        end
    end

endmodule

// File: tb/tb_exe_stage_mc.sv
module tb_exe_stage_mc;
    import exe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush, S, MEM_R_EN, MEM_W_EN, imm;
    logic [3:0]  EXE_CMD, SR;
    logic [31:0] PC, Val_Rn, Val_Rm, Val_Rs;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;

    logic        stall, out_valid, status_we;
    logic [31:0] ALU_result, Br_addr;
    logic [3:0]  status;
    logic        b_stall, b_out_valid, b_status_we;
    logic [31:0] b_ALU_result, b_Br_addr;
    logic [3:0]  b_status;

    always #5 clk = ~clk;

    exe_stage_mc #(.WIDTH(32), .MUL_BITS(1), .BR_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .EXE_CMD(EXE_CMD), .S(S), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Val_Rs(Val_Rs),
        .imm(imm), .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
        .SR(SR), .stall(stall), .out_valid(out_valid), .ALU_result(ALU_result),
        .Br_addr(Br_addr), .status(status), .status_we(status_we)
    );

    exe_stage_mc #(.WIDTH(32), .MUL_BITS(1), .BR_SHIFT(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .EXE_CMD(EXE_CMD), .S(S), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Val_Rs(Val_Rs),
        .imm(imm), .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
        .SR(SR), .stall(b_stall), .out_valid(b_out_valid), .ALU_result(b_ALU_result),
        .Br_addr(b_Br_addr), .status(b_status), .status_we(b_status_we)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] br;
        logic [3:0]  st;
        logic        we;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [3:0] exp_status;
    int         tests = 0;
    int         fails = 0;

    // Scoreboard: every committed result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output got result=%h, want no output", ALU_result);
            end else begin
                mon_e = q.pop_front();
                if (ALU_result !== mon_e.res) begin
                    fails++;
                    $display("FAIL sb_result got %h want %h", ALU_result, mon_e.res);
                end
                tests++;
                if (Br_addr !== mon_e.br) begin
                    fails++;
                    $display("FAIL sb_br_addr got %h want %h", Br_addr, mon_e.br);
                end
                tests++;
                if (status !== mon_e.st) begin
                    fails++;
                    $display("FAIL sb_status got %b want %b", status, mon_e.st);
                end
                tests++;
                if (status_we !== mon_e.we) begin
                    fails++;
                    $display("FAIL sb_status_we got %b want %b", status_we, mon_e.we);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_defaults();
        in_valid = 1'b0; flush = 1'b0; S = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        imm = 1'b0; EXE_CMD = CMD_MOV; SR = 4'b0000; PC = 32'h0;
        Val_Rn = 32'h0; Val_Rm = 32'h0; Val_Rs = 32'h0;
        Shift_operand = 12'h000; Signed_imm_24 = 24'h0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic issue_alu(input logic [3:0] cmd, input logic s, input logic im,
                             input logic mem, input logic [11:0] so,
                             input logic [31:0] rn, input logic [31:0] rm,
                             input logic [3:0] sr, input logic [31:0] exp_res,
                             input logic [3:0] exp_nzcv);
        exp_t e;
        @(negedge clk);
        EXE_CMD = cmd; S = s; imm = im; MEM_R_EN = mem; MEM_W_EN = 1'b0;
        Shift_operand = so; Val_Rn = rn; Val_Rm = rm; Val_Rs = 32'h0; SR = sr;
        flush = 1'b0; in_valid = 1'b1;
        if (s) exp_status = exp_nzcv;
        e.res = exp_res;
        e.br  = PC + {{8{Signed_imm_24[23]}}, Signed_imm_24};
        e.st  = exp_status;
        e.we  = s;
        q.push_back(e);
    endtask

    task automatic test_reset();
        set_defaults();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (ALU_result !== 32'h0) begin fails++; $display("FAIL reset_alu_result got %h want 0", ALU_result); end
        tests++; if (Br_addr !== 32'h0) begin fails++; $display("FAIL reset_br_addr got %h want 0", Br_addr); end
        tests++; if (status !== 4'h0) begin fails++; $display("FAIL reset_status got %b want 0000", status); end
        tests++; if (status_we !== 1'b0) begin fails++; $display("FAIL reset_status_we got %b want 0", status_we); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
        rst = 1'b0;
        exp_status = 4'b0000;
    endtask

    task automatic test_alu_basic();
        PC = 32'h0; Signed_imm_24 = 24'h0;
        issue_alu(CMD_ADD, 1, 1, 0, 12'h2FF, 32'h1, 32'h0, 4'b0000, 32'hF0000010, 4'b1000);
        issue_alu(CMD_SUB, 1, 0, 0, 12'h000, 32'h5, 32'h5, 4'b0000, 32'h0, 4'b0110);
        issue_alu(CMD_MVN, 1, 0, 0, 12'h000, 32'h0, 32'h0, 4'b0011, 32'hFFFFFFFF, 4'b1011);
        issue_alu(CMD_ADC, 1, 0, 0, 12'h000, 32'h7FFFFFFF, 32'h0, 4'b0010, 32'h80000000, 4'b1001);
        issue_alu(CMD_ADD, 1, 0, 0, 12'h000, 32'hFFFFFFFF, 32'h1, 4'b0000, 32'h0, 4'b0110);
        issue_alu(CMD_SUB, 1, 0, 0, 12'h000, 32'h3, 32'h5, 4'b0000, 32'hFFFFFFFE, 4'b1000);
        issue_alu(CMD_ADD, 0, 0, 1, 12'hFFF, 32'h1000, 32'h12345678, 4'b0000, 32'h1FFF, 4'b0000);
        idle();
    endtask

    task automatic test_shifts();
        issue_alu(CMD_MOV, 0, 0, 0, 12'h200, 32'h0, 32'h80000001, 4'b0000, 32'h00000010, 4'b0000);
        issue_alu(CMD_MOV, 0, 0, 0, 12'h220, 32'h0, 32'h80000001, 4'b0000, 32'h08000000, 4'b0000);
        issue_alu(CMD_MOV, 0, 0, 0, 12'h240, 32'h0, 32'h80000001, 4'b0000, 32'hF8000000, 4'b0000);
        issue_alu(CMD_MOV, 0, 0, 0, 12'h260, 32'h0, 32'h80000001, 4'b0000, 32'h18000000, 4'b0000);
        issue_alu(CMD_MOV, 0, 1, 0, 12'h0AB, 32'h0, 32'hFFFFFFFF, 4'b0000, 32'h000000AB, 4'b0000);
        issue_alu(CMD_MOV, 0, 1, 0, 12'hF01, 32'h0, 32'hFFFFFFFF, 4'b0000, 32'h00000004, 4'b0000);
        issue_alu(CMD_ADD, 0, 1, 1, 12'h2FF, 32'h0, 32'hFFFFFFFF, 4'b0000, 32'h000002FF, 4'b0000);
        idle();
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b, r;
            logic [3:0]  sr, cmd;
            logic [32:0] us;
            longint      ss;
            logic        v;
            a = $urandom; b = $urandom; sr = 4'($urandom_range(0, 15));
            case (i % 4)
                0: begin cmd = CMD_AND; r = a & b; end
                1: begin cmd = CMD_ORR; r = a | b; end
                2: begin cmd = CMD_EOR; r = a ^ b; end
                default: begin cmd = CMD_ADD; r = a + b; end
            endcase
            if (cmd == CMD_ADD) begin
                us = {1'b0, a} + {1'b0, b};
                ss = longint'($signed(a)) + longint'($signed(b));
                v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
                issue_alu(cmd, 1, 0, 0, 12'h000, a, b, sr, r, {r[31], (r == 32'd0), us[32], v});
            end else begin
                issue_alu(cmd, 1, 0, 0, 12'h000, a, b, sr, r, {r[31], (r == 32'd0), sr[1:0]});
            end
        end
        idle();
    endtask

    task automatic test_branch();
        PC = 32'h100; Signed_imm_24 = 24'hFFFFFE;
        issue_alu(CMD_MOV, 0, 0, 0, 12'h000, 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000);
        idle();
        tests++; if (Br_addr !== 32'h000000FE) begin fails++; $display("FAIL br_neg_shift0 got %h want 000000fe", Br_addr); end
        tests++; if (b_Br_addr !== 32'h000000F8) begin fails++; $display("FAIL br_neg_shift2 got %h want 000000f8", b_Br_addr); end
        PC = 32'h1000; Signed_imm_24 = 24'h000010;
        issue_alu(CMD_MOV, 0, 0, 0, 12'h000, 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000);
        idle();
        tests++; if (b_Br_addr !== 32'h00001040) begin fails++; $display("FAIL br_pos_shift2 got %h want 00001040", b_Br_addr); end
        PC = 32'h0; Signed_imm_24 = 24'h0;
    endtask

    task automatic run_mul(input logic mla, input logic [31:0] rn, input logic [31:0] rm,
                           input logic [31:0] rs, input logic [3:0] sr,
                           input logic [31:0] exp_res, input logic [3:0] exp_nzcv);
        exp_t e;
        int   n;
        @(negedge clk);
        EXE_CMD = mla ? CMD_MLA : CMD_MUL; S = 1'b1; imm = 1'b0; MEM_R_EN = 1'b0;
        Shift_operand = 12'h000; Val_Rn = rn; Val_Rm = rm; Val_Rs = rs; SR = sr;
        flush = 1'b0; in_valid = 1'b1;
        exp_status = exp_nzcv;
        e.res = exp_res; e.br = PC + {{8{Signed_imm_24[23]}}, Signed_imm_24};
        e.st = exp_status; e.we = 1'b1;
        q.push_back(e);
        #1;
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            n++;
            @(negedge clk); #1;
        end
        tests++; if (n != 33) begin fails++; $display("FAIL mul_stall_cycles got %0d want 33", n); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mul_done_early_valid got %b want 0", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mul_result_valid got %b want 1", out_valid); end
    endtask

    task automatic test_mul();
        logic [31:0] a, b, c, r;
        logic [3:0]  sr;
        run_mul(1'b0, 32'h0, 32'h0000FFFF, 32'h00010001, 4'b0000, 32'hFFFFFFFF, 4'b1000);
        run_mul(1'b1, 32'h1, 32'h0000FFFF, 32'h00010001, 4'b0010, 32'h00000000, 4'b0110);
        a = $urandom; b = $urandom; c = $urandom; sr = 4'($urandom_range(0, 15));
        r = a * b;
        run_mul(1'b0, c, a, b, sr, r, {r[31], (r == 32'd0), sr[1:0]});
        r = a * b + c;
        run_mul(1'b1, c, a, b, sr, r, {r[31], (r == 32'd0), sr[1:0]});
        idle();
    endtask

    task automatic test_flush();
        int n;
        // flush alongside a valid ALU op: nothing accepted
        @(negedge clk);
        EXE_CMD = CMD_ADD; S = 1'b1; Val_Rn = 32'h7; Val_Rm = 32'h8; Shift_operand = 12'h0;
        imm = 1'b0; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_idle_valid got %b want 0", out_valid); end

        // flush in BUSY cycle 10
        @(negedge clk);
        EXE_CMD = CMD_MUL; Val_Rm = 32'h3; Val_Rs = 32'h5; in_valid = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL flush_busy_stall got %b want 1", stall); end
        flush = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall_drop got %b want 0", stall); end
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0) n++;
        end
        tests++; if (n != 0) begin fails++; $display("FAIL flush_busy_no_output got %0d outputs want 0", n); end
        issue_alu(CMD_ADD, 1, 0, 0, 12'h000, 32'h2, 32'h3, 4'b0000, 32'h5, 4'b0000);
        idle();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL post_flush_add_valid got %b want 1", out_valid); end

        // flush during DONE beats completion
        @(negedge clk);
        EXE_CMD = CMD_MUL; Val_Rm = 32'h3; Val_Rs = 32'h5; in_valid = 1'b1; #1;
        n = 0;
        while (stall === 1'b1 && n < 200) begin n++; @(negedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_done_no_output got %b want 0", out_valid); end
        idle();
    endtask

    task automatic test_rst_mid_mul();
        PC = 32'h100; Signed_imm_24 = 24'h000004;
        issue_alu(CMD_ADD, 1, 0, 0, 12'h000, 32'h80000000, 32'h0, 4'b0000, 32'h80000000, 4'b1000);
        idle();
        @(negedge clk);
        EXE_CMD = CMD_MUL; Val_Rm = 32'h9; Val_Rs = 32'h9; in_valid = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        tests++; if (ALU_result !== 32'h0) begin fails++; $display("FAIL rst_mid_alu_result got %h want 0", ALU_result); end
        tests++; if (Br_addr !== 32'h0) begin fails++; $display("FAIL rst_mid_br_addr got %h want 0", Br_addr); end
        tests++; if (status !== 4'h0) begin fails++; $display("FAIL rst_mid_status got %b want 0000", status); end
        rst = 1'b0;
        exp_status = 4'b0000;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_mid_stall got %b want 0", stall); end
        PC = 32'h0; Signed_imm_24 = 24'h0;
        issue_alu(CMD_ORR, 1, 0, 0, 12'h000, 32'h0F0, 32'h00F, 4'b0000, 32'h0FF, 4'b0000);
        idle();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL post_rst_alu_latency got %b want 1", out_valid); end
    endtask

    task automatic test_bubble();
        issue_alu(CMD_ADD, 1, 0, 0, 12'h000, 32'h1000, 32'h0234, 4'b0000, 32'h1234, 4'b0000);
        idle();
        idle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bubble_out_valid got %b want 0", out_valid); end
        tests++; if (status_we !== 1'b0) begin fails++; $display("FAIL bubble_status_we got %b want 0", status_we); end
        tests++; if (ALU_result !== 32'h1234) begin fails++; $display("FAIL bubble_hold_result got %h want 00001234", ALU_result); end
    endtask

    initial begin
        exp_status = 4'b0000;
        test_reset();
        test_alu_basic();
        test_shifts();
        test_random_ops();
        test_branch();
        test_mul();
        test_flush();
        test_rst_mid_mul();
        test_bubble();
        repeat (3) idle();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
Parametrised, registered execute stage for the ARM-subset pipeline. It replaces the purely combinational execute path with a single-cycle ALU and an iterative multi-cycle multiplier for MUL/MLA. It also adds a pipeline stall output, flush handling and S-bit-gated status write-back. It sits between the ID/EXE register and the MEM stage, and its output register serves as the EXE/MEM register.

Parameters:
WIDTH, 32, datapath width (≥32; immediate/shift semantics computed within WIDTH)
MUL_BITS, 1, multiplier bits retired per cycle (1, 2 or 4; must divide WIDTH)
BR_SHIFT, 0, left shift applied to sign-extended Signed_imm_24 before adding to PC

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  ID/EXE holds a valid instruction
flush  in  1  kill the instruction in EXE (taken branch downstream)
EXE_CMD  in  4  op: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000, MUL 1010, MLA 1011
S  in  1  update status on completion
MEM_R_EN, MEM_W_EN  in  1 each  memory op; forces Val2 = zero-extended Shift_operand
PC  in  WIDTH  PC of the instruction
Val_Rn, Val_Rm, Val_Rs  in  WIDTH each  operands; MUL = Rm*Rs, MLA = Rm*Rs+Rn
imm  in  1  immediate operand form
Shift_operand  in  12  ARM shifter operand
Signed_imm_24  in  24  branch offset
SR  in  4  current {N,Z,C,V}; C used by ADC/SBC
stall  out  1  hold ID/EXE and earlier stages
out_valid  out  1  result register valid
ALU_result, Br_addr  out  WIDTH each  registered results
status  out  4  registered {N,Z,C,V}
status_we  out  1  status write strobe (S & completing op)

Behaviour:
- Reset: out_valid=0, ALU_result=0, Br_addr=0, status=0, status_we=0, stall=0; multiplier FSM goes to IDLE. Reset during BUSY aborts the multiply with no output.
- Val2: memory op gives zero-extended Shift_operand. Otherwise imm=1 gives Shift_operand[7:0] rotated right by 2*Shift_operand[11:8]. Otherwise Val_Rm shifted by Shift_operand[11:7] with type [6:5]: LSL, LSR, ASR, ROR.
- ALU ops: latency 1. Inputs are sampled at the edge where in_valid=1 and the FSM is IDLE; outputs appear after that edge with out_valid=1.
- Flag rules: N = result MSB; Z = result==0. C is carry-out for ADD/ADC and NOT-borrow for SUB/SBC. V is signed overflow for add/sub. Logical ops and MUL/MLA leave C and V at their SR values.
- Br_addr = PC + (sext(Signed_imm_24) << BR_SHIFT), modulo 2^WIDTH. It is registered alongside ALU_result.
- Multiplier FSM: IDLE -> BUSY on accepted MUL/MLA. In BUSY, MUL_BITS partial products are accumulated per cycle for WIDTH/MUL_BITS cycles (32 at default). On the last BUSY cycle it goes to DONE. DONE writes the low WIDTH bits of the result, pulses out_valid, and returns to IDLE.
- stall: high from the accept cycle through the last BUSY cycle, low in DONE. Total MUL occupancy = WIDTH/MUL_BITS+1 cycles. Upstream holds its inputs while stall=1; in_valid is ignored while not IDLE.
- flush: when high with in_valid, nothing is accepted (out_valid=0 next cycle). When high in BUSY or DONE, the FSM returns to IDLE with no output and stall drops the next cycle. Flush has priority over completion.
- Bubbles: when in_valid=0, out_valid=0 and status_we=0 next cycle; ALU_result holds its previous value.
- status_we = S & out_valid. status holds its value when status_we=0.
- Simultaneous rst and flush: rst wins.

Decomposition:
- Shared package (exe_pkg): EXE_CMD encodings, shift-type constants, flag bit indices, FSM state enum.
- One sub-module: val2_gen_p (combinational, parametrised by WIDTH).
- ALU and iterative multiplier stay in this module.

Test Plan:
- ADD, imm=1, Shift_operand=0x2FF, Val_Rn=1, S=1 -> Val2=0xF000000F; next cycle ALU_result=0xF0000010, status=1000, status_we=1.
- SUB Val_Rn=5, Val_Rm=5 (LSL #0), S=1 -> ALU_result=0, status=0110; MVN Rm=0 -> 0xFFFFFFFF with C/V kept from SR.
- MUL Rm=0xFFFF, Rs=0x10001, MUL_BITS=1 -> stall high 33 cycles (accept + 32 BUSY), then out_valid with 0xFFFFFFFF; MLA with Rn=1 -> 0x00000000, Z=1.
- Signed_imm_24=0xFFFFFE, PC=0x100, BR_SHIFT=0 -> Br_addr=0xFE; with BR_SHIFT=2 -> 0xF8.
- MUL accepted, flush asserted at BUSY cycle 10 -> no out_valid, stall low the following cycle, next ADD accepted normally.
- rst asserted mid-multiply, then released -> all outputs 0, stall 0; a subsequent ALU op completes in 1 cycle.
